// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle MIPS-subset datapath, with a retired-instruction counter and
// sticky illegal flag. Define MC_CTRL_MEMWAIT_EN to add the MemReady handshake on memory states.
module multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             Zero,
`ifdef MC_CTRL_MEMWAIT_EN
    input  logic             MemReady,
`endif
    output logic             PCWrite,
    output logic [1:0]       PCSrc,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             ExtOp,
    output logic [2:0]       ALUctr,
    output logic             Retire,
    output logic [CNT_W-1:0] InstrCnt,
    output logic             IllegalInstr,
    output logic [3:0]       State
);

    typedef enum logic [3:0] {
        StRst  = 4'd0,
        StIf   = 4'd1,
        StId   = 4'd2,
        StExr  = 4'd3,
        StExi  = 4'd4,
        StMadr = 4'd5,
        StMrd  = 4'd6,
        StMwr  = 4'd7,
        StWbr  = 4'd8,
        StWbi  = 4'd9,
        StWbl  = 4'd10,
        StBr   = 4'd11,
        StJmp  = 4'd12
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b100;

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_instr_cnt;
    logic             r_illegal;
    logic             w_illegal_set;
    logic             w_mem_ready;

`ifdef MC_CTRL_MEMWAIT_EN
    assign w_mem_ready = MemReady;
`else
    assign w_mem_ready = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StRst;
            r_instr_cnt <= '0;
            r_illegal   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (Retire) begin
                r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end
            if (w_illegal_set) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_illegal_set = 1'b0;
        PCWrite       = 1'b0;
        PCSrc         = 2'b00;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ExtOp         = 1'b0;
        ALUctr        = AluAdd;
        Retire        = 1'b0;
        case (r_state)
            StRst: begin
                w_state_next = StIf;
            end
            StIf: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = w_mem_ready;
                IRWrite = w_mem_ready;
                if (w_mem_ready) begin
                    w_state_next = StId;
                end
            end
            StId: begin
                // Branch target is precomputed into ALUOut while the opcode decodes.
                ALUSrcB = 2'b11;
                case (Op)
                    OpRtype: begin
                        case (Funct)
                            FnAdd, FnSub, FnAnd, FnOr, FnSlt: w_state_next = StExr;
                            default: begin
                                w_state_next  = StIf;
                                w_illegal_set = 1'b1;
                            end
                        endcase
                    end
                    OpLw, OpSw:     w_state_next = StMadr;
                    OpBeq:          w_state_next = StBr;
                    OpAddi, OpOri:  w_state_next = StExi;
                    OpJ:            w_state_next = StJmp;
                    default: begin
                        w_state_next  = StIf;
                        w_illegal_set = 1'b1;
                    end
                endcase
            end
            StExr: begin
                ALUSrcA = 1'b1;
                case (Funct)
                    FnSub:   ALUctr = AluSub;
                    FnAnd:   ALUctr = AluAnd;
                    FnOr:    ALUctr = AluOr;
                    FnSlt:   ALUctr = AluSlt;
                    default: ALUctr = AluAdd;
                endcase
                w_state_next = StWbr;
            end
            StExi: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (Op == OpOri) begin
                    ALUctr = AluOr;
                end else begin
                    ExtOp = 1'b1;
                end
                w_state_next = StWbi;
            end
            StMadr: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                ExtOp        = 1'b1;
                w_state_next = (Op == OpSw) ? StMwr : StMrd;
            end
            StMrd: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (w_mem_ready) begin
                    w_state_next = StWbl;
                end
            end
            StMwr: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                Retire   = w_mem_ready;
                if (w_mem_ready) begin
                    w_state_next = StIf;
                end
            end
            StWbr: begin
                RegWrite     = 1'b1;
                RegDst       = 1'b1;
                Retire       = 1'b1;
                w_state_next = StIf;
            end
            StWbi: begin
                RegWrite     = 1'b1;
                Retire       = 1'b1;
                w_state_next = StIf;
            end
            StWbl: begin
                RegWrite     = 1'b1;
                MemtoReg     = 1'b1;
                Retire       = 1'b1;
                w_state_next = StIf;
            end
            StBr: begin
                // PCWrite follows Zero combinationally so the ALU compare resolves this cycle.
                ALUSrcA      = 1'b1;
                ALUctr       = AluSub;
                PCSrc        = 2'b01;
                PCWrite      = Zero;
                Retire       = 1'b1;
                w_state_next = StIf;
            end
            StJmp: begin
                PCSrc        = 2'b10;
                PCWrite      = 1'b1;
                Retire       = 1'b1;
                w_state_next = StIf;
            end
            default: begin
                w_state_next  = StIf;
                w_illegal_set = 1'b1;
            end
        endcase
    end

    assign InstrCnt     = r_instr_cnt;
    assign IllegalInstr = r_illegal;
    assign State        = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (CNT_W=4 so the counter wrap is reachable).
module tb_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
`ifdef MC_CTRL_MEMWAIT_EN
    logic       MemReady;
`endif
    logic       PCWrite;
    logic [1:0] PCSrc;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ExtOp;
    logic [2:0] ALUctr;
    logic       Retire;
    logic [3:0] InstrCnt;
    logic       IllegalInstr;
    logic [3:0] State;

    int n_cmp;
    int n_err;

    multicycle_ctrl #(.CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .Op           (Op),
        .Funct        (Funct),
        .Zero         (Zero),
`ifdef MC_CTRL_MEMWAIT_EN
        .MemReady     (MemReady),
`endif
        .PCWrite      (PCWrite),
        .PCSrc        (PCSrc),
        .IorD         (IorD),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .IRWrite      (IRWrite),
        .RegDst       (RegDst),
        .MemtoReg     (MemtoReg),
        .RegWrite     (RegWrite),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ExtOp        (ExtOp),
        .ALUctr       (ALUctr),
        .Retire       (Retire),
        .InstrCnt     (InstrCnt),
        .IllegalInstr (IllegalInstr),
        .State        (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Concatenation of every strobe/select, all zero in RST.
    function automatic logic [31:0] all_ctrl();
        return {11'd0, PCWrite, PCSrc, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
                RegWrite, ALUSrcA, ALUSrcB, ExtOp, ALUctr, Retire};
    endfunction

    // Starts at a negedge in IF; runs until the FSM is back in IF (bounded).
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, output int cycles,
                             output int retires, output int bad_mtr, output int bad_mw,
                             output int pcw);
        Op      = op;
        Funct   = fn;
        cycles  = 0;
        retires = 0;
        bad_mtr = 0;
        bad_mw  = 0;
        pcw     = 0;
        #1;
        do begin
            if (Retire) retires++;
            if (PCWrite) pcw++;
            if (MemtoReg && State != 4'd10) bad_mtr++;
            if (MemWrite && State != 4'd7) bad_mw++;
            @(negedge clk);
            cycles++;
        end while (State != 4'd1 && cycles < 20);
    endtask

    int cyc, ret, bmtr, bmw, pcw;

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        Op    = 6'b000000;
        Funct = 6'b100000;
        Zero  = 1'b0;
`ifdef MC_CTRL_MEMWAIT_EN
        MemReady = 1'b1;
`endif
        repeat (2) @(negedge clk);
        chk("rst_state", State, 0);
        chk("rst_ctrl", all_ctrl(), 0);
        chk("rst_cnt", InstrCnt, 0);
        chk("rst_illegal", IllegalInstr, 0);

        // add: RST -> IF -> ID -> EXR -> WBR
        reset = 1'b0;
        @(negedge clk);
        chk("if_state", State, 1);
        chk("if_ctrl", {MemRead, IorD, IRWrite, ALUSrcA, ALUSrcB, PCWrite, PCSrc},
            {1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 2'b00});
        @(negedge clk);
        chk("id_state", State, 2);
        chk("id_alusrcb", ALUSrcB, 2'b11);
        @(negedge clk);
        chk("exr_state", State, 3);
        chk("exr_aluctr", {ALUSrcA, ALUSrcB, ALUctr}, {1'b1, 2'b00, 3'b000});
        @(negedge clk);
        chk("wbr_state", State, 8);
        chk("wbr_ctrl", {RegWrite, RegDst, MemtoReg, Retire}, 4'b1101);
        chk("wbr_cnt_pre", InstrCnt, 0);
        @(negedge clk);
        chk("add_back_if", State, 1);
        chk("add_cnt", InstrCnt, 1);

        // sub through EXR for the ALUctr decode
        Funct = 6'b100010;
        repeat (2) @(negedge clk);
        chk("exr_sub", ALUctr, 3'b001);
        repeat (2) @(negedge clk);

        // lw and sw latencies and exclusive strobes
        run_instr(6'b100011, 6'd0, cyc, ret, bmtr, bmw, pcw);
        chk("lw_cycles", cyc, 5);
        chk("lw_retire", ret, 1);
        chk("lw_mtr_only_wbl", bmtr, 0);
        run_instr(6'b101011, 6'd0, cyc, ret, bmtr, bmw, pcw);
        chk("sw_cycles", cyc, 4);
        chk("sw_mw_only_mwr", bmw, 0);
        chk("sw_cnt", InstrCnt, 4);

        // beq taken, with PCWrite following Zero inside BR
        Op = 6'b000100;
        repeat (2) @(negedge clk);
        Zero = 1'b1;
        #1;
        chk("br_state", State, 11);
        chk("br_taken", {PCWrite, PCSrc, ALUctr, Retire}, {1'b1, 2'b01, 3'b001, 1'b1});
        Zero = 1'b0;
        #1;
        chk("br_mealy", PCWrite, 0);
        @(negedge clk);
        chk("beq1_cnt", InstrCnt, 5);
        run_instr(6'b000100, 6'd0, cyc, ret, bmtr, bmw, pcw);
        chk("beq0_cycles", cyc, 3);
        chk("beq0_retire", ret, 1);
        chk("beq0_pcw_if_only", pcw, 1);

        // illegal opcode: ID -> IF, no retire, sticky flag
        run_instr(6'b111111, 6'd0, cyc, ret, bmtr, bmw, pcw);
        chk("ill_cycles", cyc, 2);
        chk("ill_flag", IllegalInstr, 1);
        chk("ill_cnt", InstrCnt, 6);
        run_instr(6'b000000, 6'b111111, cyc, ret, bmtr, bmw, pcw);
        chk("ill_funct_cycles", cyc, 2);
        chk("ill_funct_cnt", InstrCnt, 6);

        // addi / ori through EXI
        Op = 6'b001000;
        repeat (2) @(negedge clk);
        chk("exi_addi", {State, ALUSrcA, ALUSrcB, ExtOp, ALUctr}, {4'd4, 1'b1, 2'b10, 1'b1, 3'b000});
        repeat (2) @(negedge clk);
        Op = 6'b001101;
        repeat (2) @(negedge clk);
        chk("exi_ori", {ExtOp, ALUctr}, {1'b0, 3'b011});
        repeat (2) @(negedge clk);
        chk("ori_cnt", InstrCnt, 8);
        chk("ill_sticky", IllegalInstr, 1);

        // j until the 4-bit counter reaches 15, then one more wraps it
        for (int i = 0; i < 7; i++) begin
            run_instr(6'b000010, 6'd0, cyc, ret, bmtr, bmw, pcw);
        end
        chk("j_cycles", cyc, 3);
        chk("cnt_max", InstrCnt, 15);
        run_instr(6'b000010, 6'd0, cyc, ret, bmtr, bmw, pcw);
        chk("cnt_wrap", InstrCnt, 0);

        // reset in MRD drops strobes without waiting for a clock edge
        Op = 6'b100011;
        repeat (3) @(negedge clk);
        chk("mrd_state", {State, MemRead, IorD}, {4'd6, 1'b1, 1'b1});
        #2;
        reset = 1'b1;
        #1;
        chk("async_state", State, 0);
        chk("async_ctrl", all_ctrl(), 0);
        chk("async_illegal", IllegalInstr, 0);

`ifdef MC_CTRL_MEMWAIT_EN
        MemReady = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        pcw   = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (PCWrite) pcw++;
            chk("wait_if_hold", State, 1);
        end
        MemReady = 1'b1;
        #1;
        if (PCWrite) pcw++;
        @(negedge clk);
        chk("wait_single_pcw", pcw, 1);
        chk("wait_to_id", State, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
